// File: rtl/vga_sram_arbiter_pkg.sv
// Shared definitions for the VGA/CPU SRAM arbiter: FSM state encoding,
// default address width and halfword select helpers.
package vga_sram_arbiter_pkg;

    localparam int ADR_W_DEF = 18;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_VID0 = 3'd1,
        ST_VID1 = 3'd2,
        ST_LO0  = 3'd3,
        ST_LO1  = 3'd4,
        ST_HI0  = 3'd5,
        ST_HI1  = 3'd6,
        ST_ACK  = 3'd7
    } arb_st_e;

    // Byte enables (active high) of the low or high halfword of a 32-bit select
    function automatic logic [1:0] hw_sel(input logic [3:0] sel, input logic hi);
        return hi ? sel[3:2] : sel[1:0];
    endfunction

    // First cycle of a halfword access (address/data setup)
    function automatic logic is_x0(input arb_st_e s);
        return (s == ST_VID0) || (s == ST_LO0) || (s == ST_HI0);
    endfunction

    // Second cycle of a halfword access (oe_n / we_n strobe)
    function automatic logic is_x1(input arb_st_e s);
        return (s == ST_VID1) || (s == ST_LO1) || (s == ST_HI1);
    endfunction

endpackage

// File: rtl/vga_sram_arbiter_if.sv
// Bus bundle of the arbiter: video fetch port, CPU Wishbone slave port and
// SRAM pins. slave = arbiter side, master = surrounding system.
// Optional O_vid_overrun exists only with SRAM_ARB_OVERRUN_DET_EN defined.
interface vga_sram_arbiter_if #(parameter int ADR_W = 18);
    logic             I_vid_req;
    logic [ADR_W-1:0] I_vid_adr;
    logic             O_vid_ack;
    logic [15:0]      O_vid_dat;
`ifdef SRAM_ARB_OVERRUN_DET_EN
    logic             O_vid_overrun;
`endif
    logic [ADR_W-2:0] I_wb_adr;
    logic [3:0]       I_wb_sel;
    logic [31:0]      I_wb_dat;
    logic             I_wb_stb;
    logic             I_wb_we;
    logic             O_wb_ack;
    logic [31:0]      O_wb_dat;
    logic [ADR_W-1:0] O_sram_adr;
    logic [15:0]      I_sram_dat;
    logic [15:0]      O_sram_dat;
    logic             O_sram_oe;
    logic             O_sram_ce_n;
    logic             O_sram_oe_n;
    logic             O_sram_we_n;
    logic             O_sram_lb_n;
    logic             O_sram_ub_n;

    modport slave (
`ifdef SRAM_ARB_OVERRUN_DET_EN
        output O_vid_overrun,
`endif
        input  I_vid_req, I_vid_adr, I_wb_adr, I_wb_sel, I_wb_dat, I_wb_stb, I_wb_we,
        input  I_sram_dat,
        output O_vid_ack, O_vid_dat, O_wb_ack, O_wb_dat,
        output O_sram_adr, O_sram_dat, O_sram_oe,
        output O_sram_ce_n, O_sram_oe_n, O_sram_we_n, O_sram_lb_n, O_sram_ub_n
    );

    modport master (
`ifdef SRAM_ARB_OVERRUN_DET_EN
        input  O_vid_overrun,
`endif
        output I_vid_req, I_vid_adr, I_wb_adr, I_wb_sel, I_wb_dat, I_wb_stb, I_wb_we,
        output I_sram_dat,
        input  O_vid_ack, O_vid_dat, O_wb_ack, O_wb_dat,
        input  O_sram_adr, O_sram_dat, O_sram_oe,
        input  O_sram_ce_n, O_sram_oe_n, O_sram_we_n, O_sram_lb_n, O_sram_ub_n
    );
endinterface

// File: rtl/vga_sram_arbiter_sram_phy_cycle.sv
// Two-cycle halfword SRAM engine. The caller flags which phase the NEXT
// cycle is (i_x0 / i_x1) so every pin comes straight from a flop.
// X0: address, byte lanes, write data, ce_n low. X1: oe_n (read) or
// we_n + data drive enable (write).
module sram_phy_cycle #(
    parameter int ADR_W = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_x0,
    input  logic             i_x1,
    input  logic             i_we,
    input  logic [ADR_W-1:0] i_adr,
    input  logic [1:0]       i_be,
    input  logic [15:0]      i_wdat,
    output logic [ADR_W-1:0] o_adr,
    output logic [15:0]      o_dat,
    output logic             o_oe,
    output logic             o_ce_n,
    output logic             o_oe_n,
    output logic             o_we_n,
    output logic             o_lb_n,
    output logic             o_ub_n
);
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [15:0]      dat_q, dat_d;
    logic             we_q, we_d;
    logic             oe_q, oe_d;
    logic             ce_n_q, ce_n_d;
    logic             oe_n_q, oe_n_d;
    logic             we_n_q, we_n_d;
    logic             lb_n_q, lb_n_d;
    logic             ub_n_q, ub_n_d;

    // Next pin state: access parameters latched at X0, held through X1
    always_comb begin
        adr_d  = i_x0 ? i_adr  : adr_q;
        dat_d  = i_x0 ? i_wdat : dat_q;
        we_d   = i_x0 ? i_we   : we_q;
        ce_n_d = !(i_x0 || i_x1);
        oe_n_d = !(i_x1 && !we_q);
        we_n_d = !(i_x1 && we_q);
        oe_d   = i_x1 && we_q;
        lb_n_d = 1'b1;
        ub_n_d = 1'b1;
        if (i_x0) begin
            lb_n_d = !i_be[0];
            ub_n_d = !i_be[1];
        end else if (i_x1) begin
            lb_n_d = lb_n_q;
            ub_n_d = ub_n_q;
        end
    end

    // Pin registers; reset drops every strobe at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adr_q  <= '0;
            dat_q  <= '0;
            we_q   <= 1'b0;
            oe_q   <= 1'b0;
            ce_n_q <= 1'b1;
            oe_n_q <= 1'b1;
            we_n_q <= 1'b1;
            lb_n_q <= 1'b1;
            ub_n_q <= 1'b1;
        end else begin
            adr_q  <= adr_d;
            dat_q  <= dat_d;
            we_q   <= we_d;
            oe_q   <= oe_d;
            ce_n_q <= ce_n_d;
            oe_n_q <= oe_n_d;
            we_n_q <= we_n_d;
            lb_n_q <= lb_n_d;
            ub_n_q <= ub_n_d;
        end
    end

    assign o_adr  = adr_q;
    assign o_dat  = dat_q;
    assign o_oe   = oe_q;
    assign o_ce_n = ce_n_q;
    assign o_oe_n = oe_n_q;
    assign o_we_n = we_n_q;
    assign o_lb_n = lb_n_q;
    assign o_ub_n = ub_n_q;
endmodule

// File: rtl/vga_sram_arbiter.sv
// SRAM arbiter: video fetches have priority, CPU 32-bit Wishbone accesses
// are split into low/high halfword cycles with at most one video read
// slipped in between. Optional `SRAM_ARB_OVERRUN_DET_EN adds a sticky
// O_vid_overrun flag for a video toggle that cancels a pending request.
module vga_sram_arbiter
    import vga_sram_arbiter_pkg::*;
#(
    parameter int ADR_W = ADR_W_DEF
) (
    input logic               I_clk,
    input logic               I_reset,
    vga_sram_arbiter_if.slave bus
);
    arb_st_e     st_q, st_d;
    logic        vid_ack_q, vid_ack_d;
    logic [15:0] vid_dat_q, vid_dat_d;
    logic        wb_ack_q, wb_ack_d;
    logic [31:0] wb_dat_q, wb_dat_d;
    logic        hi_pending_q, hi_pending_d;
    logic        ack_given_q, ack_given_d;
    logic        vid_pend;

    logic             phy_x0, phy_x1, phy_we, phy_hi, phy_vid;
    logic [ADR_W-1:0] phy_adr;
    logic [1:0]       phy_be;
    logic [15:0]      phy_wdat;

    assign vid_pend = (bus.I_vid_req != vid_ack_q);

    // Arbiter next-state and registered-output computation
    always_comb begin
        st_d         = st_q;
        vid_ack_d    = vid_ack_q;
        vid_dat_d    = vid_dat_q;
        wb_dat_d     = wb_dat_q;
        hi_pending_d = hi_pending_q;
        // stb is still high the cycle after ack; that must not restart a cycle
        ack_given_d  = (st_q == ST_ACK);
        case (st_q)
            ST_IDLE: begin
                if (vid_pend) begin
                    st_d = ST_VID0;
                end else if (bus.I_wb_stb && !ack_given_q) begin
                    if (bus.I_wb_sel == 4'b0000)     st_d = ST_ACK;
                    else if (bus.I_wb_sel[1:0] == 2'b00) st_d = ST_HI0;
                    else                             st_d = ST_LO0;
                end
            end
            ST_VID0: st_d = ST_VID1;
            ST_VID1: begin
                vid_dat_d = bus.I_sram_dat;
                vid_ack_d = !vid_ack_q;
                st_d      = hi_pending_q ? ST_HI0 : ST_IDLE;
            end
            ST_LO0: st_d = ST_LO1;
            ST_LO1: begin
                if (!bus.I_wb_we) wb_dat_d[15:0] = bus.I_sram_dat;
                if (bus.I_wb_sel[3:2] == 2'b00) begin
                    st_d = ST_ACK;
                end else if (vid_pend) begin
                    hi_pending_d = 1'b1;
                    st_d         = ST_VID0;
                end else begin
                    st_d = ST_HI0;
                end
            end
            ST_HI0: st_d = ST_HI1;
            ST_HI1: begin
                if (!bus.I_wb_we) wb_dat_d[31:16] = bus.I_sram_dat;
                hi_pending_d = 1'b0;
                st_d         = ST_ACK;
            end
            ST_ACK: st_d = ST_IDLE;
            default: st_d = ST_IDLE;
        endcase
        wb_ack_d = (st_d == ST_ACK);
    end

    // Setup for the halfword engine, derived from the state being entered
    always_comb begin
        phy_x0   = is_x0(st_d);
        phy_x1   = is_x1(st_d);
        phy_vid  = (st_d == ST_VID0);
        phy_hi   = (st_d == ST_HI0);
        phy_we   = !phy_vid && bus.I_wb_we;
        phy_adr  = phy_vid ? bus.I_vid_adr : {bus.I_wb_adr, phy_hi};
        phy_be   = phy_vid ? 2'b11 : hw_sel(bus.I_wb_sel, phy_hi);
        phy_wdat = phy_hi ? bus.I_wb_dat[31:16] : bus.I_wb_dat[15:0];
    end

    // Arbiter FSM and its registered outputs
    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            st_q         <= ST_IDLE;
            vid_ack_q    <= 1'b0;
            vid_dat_q    <= '0;
            wb_ack_q     <= 1'b0;
            wb_dat_q     <= '0;
            hi_pending_q <= 1'b0;
            ack_given_q  <= 1'b0;
        end else begin
            st_q         <= st_d;
            vid_ack_q    <= vid_ack_d;
            vid_dat_q    <= vid_dat_d;
            wb_ack_q     <= wb_ack_d;
            wb_dat_q     <= wb_dat_d;
            hi_pending_q <= hi_pending_d;
            ack_given_q  <= ack_given_d;
        end
    end

    sram_phy_cycle #(.ADR_W(ADR_W)) u_phy (
        .clk    (I_clk),
        .rst    (I_reset),
        .i_x0   (phy_x0),
        .i_x1   (phy_x1),
        .i_we   (phy_we),
        .i_adr  (phy_adr),
        .i_be   (phy_be),
        .i_wdat (phy_wdat),
        .o_adr  (bus.O_sram_adr),
        .o_dat  (bus.O_sram_dat),
        .o_oe   (bus.O_sram_oe),
        .o_ce_n (bus.O_sram_ce_n),
        .o_oe_n (bus.O_sram_oe_n),
        .o_we_n (bus.O_sram_we_n),
        .o_lb_n (bus.O_sram_lb_n),
        .o_ub_n (bus.O_sram_ub_n)
    );

    assign bus.O_vid_ack = vid_ack_q;
    assign bus.O_vid_dat = vid_dat_q;
    assign bus.O_wb_ack  = wb_ack_q;
    assign bus.O_wb_dat  = wb_dat_q;

`ifdef SRAM_ARB_OVERRUN_DET_EN
    logic vid_req_q, vid_req_d;
    logic ovr_q, ovr_d;

    // A toggle while a request was already pending cancels it: flag sticky
    always_comb begin
        vid_req_d = bus.I_vid_req;
        ovr_d     = ovr_q || ((vid_req_q != vid_ack_q) && (bus.I_vid_req != vid_req_q));
    end

    // Overrun detector state
    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            vid_req_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            vid_req_q <= vid_req_d;
            ovr_q     <= ovr_d;
        end
    end

    assign bus.O_vid_overrun = ovr_q;
`endif
endmodule

// File: tb/tb_vga_sram_arbiter.sv
// Directed bench for vga_sram_arbiter with a behavioural async SRAM model.
module tb_vga_sram_arbiter;
    localparam int ADR_W = 18;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_sram_arbiter_if #(.ADR_W(ADR_W)) bus();

    vga_sram_arbiter #(.ADR_W(ADR_W)) dut (
        .I_clk   (clk),
        .I_reset (rst),
        .bus     (bus)
    );

    // SRAM model: combinational read, byte-lane write at the end of the we_n cycle
    logic [15:0] mem [0:(1<<ADR_W)-1];
    int          wr_cnt = 0;
    logic [ADR_W-1:0] last_wr_adr = '0;
    logic        last_lb = 1'b1, last_ub = 1'b1;
    assign bus.I_sram_dat = (!bus.O_sram_ce_n && !bus.O_sram_oe_n) ? mem[bus.O_sram_adr] : 16'hDEAD;
    always @(posedge clk) begin
        if (!bus.O_sram_ce_n && !bus.O_sram_we_n && bus.O_sram_oe) begin
            if (!bus.O_sram_lb_n) mem[bus.O_sram_adr][7:0]  <= bus.O_sram_dat[7:0];
            if (!bus.O_sram_ub_n) mem[bus.O_sram_adr][15:8] <= bus.O_sram_dat[15:8];
            wr_cnt      <= wr_cnt + 1;
            last_wr_adr <= bus.O_sram_adr;
            last_lb     <= bus.O_sram_lb_n;
            last_ub     <= bus.O_sram_ub_n;
        end
    end

    // Address seen on the pins in every chip-enabled cycle
    logic [ADR_W-1:0] adr_log [$];
    always @(negedge clk) if (!bus.O_sram_ce_n) adr_log.push_back(bus.O_sram_adr);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wait for the wb ack pulse; n = cycles taken, -1 on timeout
    task automatic wait_ack(output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus.O_wb_ack) begin n = i; break; end
        end
    endtask

    task automatic wb_start(input logic [ADR_W-2:0] adr, input logic [3:0] sel,
                            input logic [31:0] dat, input logic we);
        repeat (2) @(posedge clk);
        #1;
        bus.I_wb_adr = adr;
        bus.I_wb_sel = sel;
        bus.I_wb_dat = dat;
        bus.I_wb_we  = we;
        bus.I_wb_stb = 1'b1;
    endtask

    task automatic wb_xfer(input logic [ADR_W-2:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat, input logic we, output int n);
        wb_start(adr, sel, dat, we);
        wait_ack(n);
        bus.I_wb_stb = 1'b0;
    endtask

    initial begin
        int n, vn, wr0, base;
        logic ack0;
        logic [ADR_W-1:0] exp_adr [6];

        bus.I_vid_req = 1'b0;
        bus.I_vid_adr = '0;
        bus.I_wb_adr  = '0;
        bus.I_wb_sel  = '0;
        bus.I_wb_dat  = '0;
        bus.I_wb_stb  = 1'b0;
        bus.I_wb_we   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vid_ack", {31'd0, bus.O_vid_ack}, 32'd0);
        chk("rst_vid_dat", {16'd0, bus.O_vid_dat}, 32'd0);
        chk("rst_wb_ack", {31'd0, bus.O_wb_ack}, 32'd0);
        chk("rst_wb_dat", bus.O_wb_dat, 32'd0);
        chk("rst_sram_adr", {14'd0, bus.O_sram_adr}, 32'd0);
        chk("rst_sram_oe", {31'd0, bus.O_sram_oe}, 32'd0);
        chk("rst_strobes", {27'd0, bus.O_sram_ce_n, bus.O_sram_oe_n, bus.O_sram_we_n,
                            bus.O_sram_lb_n, bus.O_sram_ub_n}, 32'h1f);
`ifdef SRAM_ARB_OVERRUN_DET_EN
        chk("rst_overrun", {31'd0, bus.O_vid_overrun}, 32'd0);
`endif
        rst = 1'b0;

        // 32-bit write, then stb held through the following idle cycle
        wb_start(17'h00010, 4'b1111, 32'h12345678, 1'b1);
        wait_ack(n);
        chk("wr32_lat", n, 5);
        @(posedge clk); #1;
        chk("wr32_ack_pulse", {31'd0, bus.O_wb_ack}, 32'd0);
        @(posedge clk); #1;
        chk("wr32_no_restart", {31'd0, bus.O_sram_ce_n}, 32'd1);
        bus.I_wb_stb = 1'b0;
        chk("wr32_lo", {16'd0, mem[18'h20]}, 32'h5678);
        chk("wr32_hi", {16'd0, mem[18'h21]}, 32'h1234);
        chk("wr32_cnt", wr_cnt, 2);

        // Single byte write in the high halfword
        wr0 = wr_cnt;
        wb_xfer(17'h00010, 4'b0100, 32'h00AB0000, 1'b1, n);
        chk("bw_lat", n, 3);
        chk("bw_cnt", wr_cnt - wr0, 1);
        chk("bw_adr", {14'd0, last_wr_adr}, 32'h21);
        chk("bw_lanes", {30'd0, last_lb, last_ub}, 32'b01);
        chk("bw_hi", {16'd0, mem[18'h21]}, 32'h12AB);
        chk("bw_lo", {16'd0, mem[18'h20]}, 32'h5678);

        // Preload for video and read tests
        wb_xfer(17'h10000, 4'b0011, 32'h0000BEEF, 1'b1, n);
        wb_xfer(17'h00030, 4'b1111, 32'h44443333, 1'b1, n);
        wb_xfer(17'h00080, 4'b0011, 32'h00007777, 1'b1, n);
        chk("pre_vid", {16'd0, mem[18'h20000]}, 32'hBEEF);

        // Video read on an idle bus
        repeat (2) @(posedge clk);
        #1;
        bus.I_vid_adr = 18'h20000;
        bus.I_vid_req = ~bus.O_vid_ack;
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus.O_vid_ack == bus.I_vid_req) begin n = i; break; end
        end
        chk("vid_lat", n, 3);
        chk("vid_dat", {16'd0, bus.O_vid_dat}, 32'hBEEF);
        chk("vid_ack", {31'd0, bus.O_vid_ack}, 32'd1);

        // CPU read with a video toggle during LO0
        exp_adr = '{18'h60, 18'h60, 18'h100, 18'h100, 18'h61, 18'h61};
        base = adr_log.size();
        wb_start(17'h00030, 4'b1111, 32'h0, 1'b0);
        bus.I_vid_adr = 18'h100;
        n = -1; vn = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (i == 1) bus.I_vid_req = ~bus.I_vid_req;
            else if (vn == 0 && bus.O_vid_ack == bus.I_vid_req) vn = i;
            if (bus.O_wb_ack) begin n = i; break; end
        end
        bus.I_wb_stb = 1'b0;
        chk("rdv_wb_lat", n, 7);
        chk("rdv_vid_lat", vn, 5);
        chk("rdv_vid_dat", {16'd0, bus.O_vid_dat}, 32'h7777);
        chk("rdv_wb_dat", bus.O_wb_dat, 32'h44443333);
        chk("rdv_seq_len", adr_log.size() - base, 6);
        for (int i = 0; i < 6; i++)
            if (base + i < adr_log.size())
                chk($sformatf("rdv_seq%0d", i), {14'd0, adr_log[base + i]}, {14'd0, exp_adr[i]});

        // Upper-half read keeps the low half of O_wb_dat
        wb_xfer(17'h00030, 4'b0011, 32'h00005555, 1'b1, n);
        wb_xfer(17'h00030, 4'b1100, 32'h99990000, 1'b1, n);
        wb_xfer(17'h00030, 4'b1100, 32'h0, 1'b0, n);
        chk("rdhi_lat", n, 3);
        chk("rdhi_dat", bus.O_wb_dat, 32'h99993333);

        // Empty select acks without touching the SRAM
        wr0 = wr_cnt;
        base = adr_log.size();
        wb_xfer(17'h00030, 4'b0000, 32'h0, 1'b0, n);
        chk("sel0_lat", n, 1);
        chk("sel0_dat", bus.O_wb_dat, 32'h99993333);
        chk("sel0_noacc", adr_log.size() - base, 0);

        // Double toggle during LO0 cancels the video request
        ack0 = bus.O_vid_ack;
        wb_start(17'h00070, 4'b1111, 32'hCAFEF00D, 1'b1);
        @(posedge clk); #1;
        bus.I_vid_req = ~bus.I_vid_req;
        @(posedge clk); #1;
        bus.I_vid_req = ~bus.I_vid_req;
        wait_ack(n);
        bus.I_wb_stb = 1'b0;
        chk("dbl_lat", n, 3);
        chk("dbl_no_vid", {31'd0, bus.O_vid_ack}, {31'd0, ack0});
`ifdef SRAM_ARB_OVERRUN_DET_EN
        chk("ovr_set", {31'd0, bus.O_vid_overrun}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("ovr_sticky", {31'd0, bus.O_vid_overrun}, 32'd1);
`endif

        // Async reset during HI1 of a write, then automatic retry
        wr0 = wr_cnt;
        wb_start(17'h00050, 4'b1111, 32'hAAAABBBB, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("rsthi_we_before", {31'd0, bus.O_sram_we_n}, 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("rsthi_we_n", {31'd0, bus.O_sram_we_n}, 32'd1);
        chk("rsthi_ce_n", {31'd0, bus.O_sram_ce_n}, 32'd1);
        chk("rsthi_oe", {31'd0, bus.O_sram_oe}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rsthi_no_ack", {31'd0, bus.O_wb_ack}, 32'd0);
        chk("rsthi_wr_cnt", wr_cnt - wr0, 1);
        rst = 1'b0;
        wait_ack(n);
        bus.I_wb_stb = 1'b0;
        chk("retry_lat", n, 5);
        chk("retry_lo", {16'd0, mem[18'hA0]}, 32'hBBBB);
        chk("retry_hi", {16'd0, mem[18'hA1]}, 32'hAAAA);
        chk("retry_cnt", wr_cnt - wr0, 3);
`ifdef SRAM_ARB_OVERRUN_DET_EN
        chk("ovr_cleared", {31'd0, bus.O_vid_overrun}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case the flow above stalls
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
